// File: rtl/inst_fetch_bus_if_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch bus interface.
package inst_fetch_bus_if_pkg;

  localparam logic        RstEnable  = 1'b1;
  localparam logic        ChipEnable = 1'b1;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [31:0] NopInst    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IfIdle  = 2'd0,
    IfBusy  = 2'd1,
    IfHold  = 2'd2,
    IfDrain = 2'd3
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_bus_if_if.sv
// Single-beat instruction memory bus: cycle/strobe/address out, data/ack back.
interface inst_fetch_bus_if_if;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;

  // Handshake: the master holds cyc/stb and a stable address until the slave
  // returns a one-cycle ack; data is valid only in the ack cycle, and cyc/stb
  // fall on the edge after ack.
  modport master (
    output bus_cyc_o, bus_stb_o, bus_addr_o,
    input  bus_data_i, bus_ack_i
  );

  modport slave (
    input  bus_cyc_o, bus_stb_o, bus_addr_o,
    output bus_data_i, bus_ack_i
  );
endinterface

// File: rtl/inst_fetch_bus_if.sv
// Turns each PC-stage fetch address into one bus read, stalls the pipeline
// while it is outstanding and absorbs flushes without breaking the bus cycle.
module inst_fetch_bus_if
  import inst_fetch_bus_if_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              excepttype_i,
  input  logic [5:0]               stall,
  input  logic                     flush,
  output logic [31:0]              inst_o,
  output logic [31:0]              excepttype_o,
  output logic                     stallreq,
  inst_fetch_bus_if_if.master      bus,
  output if_state_e                dbg_state
);

  if_state_e   state;
  logic [31:0] inst_q;
  logic        accept;
  logic        stall_any;

  assign accept    = (ce_i == ChipEnable) && !flush && (excepttype_i == ZeroWord);
  assign stall_any = (stall != 6'd0);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state          <= IfIdle;
      bus.bus_cyc_o  <= 1'b0;
      bus.bus_stb_o  <= 1'b0;
      bus.bus_addr_o <= ZeroWord;
      inst_q         <= NOP_INST;
    end else begin
      case (state)
        IfIdle: begin
          if (accept) begin
            state          <= IfBusy;
            bus.bus_cyc_o  <= 1'b1;
            bus.bus_stb_o  <= 1'b1;
            bus.bus_addr_o <= word_align(pc_i);
          end
        end
        IfBusy: begin
          if (bus.bus_ack_i) begin
            bus.bus_cyc_o <= 1'b0;
            bus.bus_stb_o <= 1'b0;
            if (flush) begin
              state <= IfIdle;
            end else begin
              inst_q <= bus.bus_data_i;
              state  <= stall_any ? IfHold : IfIdle;
            end
          end else if (flush) begin
            // The slave cannot be told to abort, so keep the cycle open and wait.
            state <= IfDrain;
          end
        end
        IfHold: begin
          if (flush || !stall_any) state <= IfIdle;
        end
        IfDrain: begin
          if (bus.bus_ack_i) begin
            bus.bus_cyc_o <= 1'b0;
            bus.bus_stb_o <= 1'b0;
            state         <= IfIdle;
          end
        end
        default: state <= IfIdle;
      endcase
    end
  end

  always_comb begin
    stallreq     = 1'b0;
    inst_o       = NOP_INST;
    excepttype_o = ZeroWord;
    case (state)
      IfIdle: begin
        stallreq     = accept;
        excepttype_o = excepttype_i;
      end
      IfBusy: begin
        if (bus.bus_ack_i) begin
          if (!flush) inst_o = bus.bus_data_i;
        end else begin
          stallreq = 1'b1;
        end
      end
      IfHold:  inst_o   = inst_q;
      IfDrain: stallreq = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_bus_if.sv
// Directed and randomized fetch transactions checked against per-cycle
// expectations derived from the fetch/flush/stall rules.
module tb_inst_fetch_bus_if;
  import inst_fetch_bus_if_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [31:0] excepttype_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] inst_o;
  logic [31:0] excepttype_o;
  logic        stallreq;
  if_state_e   dbg_state;

  int checks   = 0;
  int failures = 0;

  inst_fetch_bus_if_if bus_if ();

  inst_fetch_bus_if #(.NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .pc_i         (pc_i),
    .excepttype_i (excepttype_i),
    .stall        (stall),
    .flush        (flush),
    .inst_o       (inst_o),
    .excepttype_o (excepttype_o),
    .stallreq     (stallreq),
    .bus          (bus_if.master),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One fetch: ack after `waits` BUSY wait cycles, optional flush in BUSY
  // cycle `flush_at` (1-based, 0 = none), `hold` stalled cycles after completion.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data,
                       input int waits, input int flush_at, input int hold,
                       input bit flush_in_hold);
    int  ack_k;
    bit  drained;
    bit  completed;
    ack_k   = waits + 1;
    drained = 1'b0;

    ce_i = 1'b1; pc_i = pc; excepttype_i = 32'h0; flush = 1'b0; stall = 6'd0;
    bus_if.bus_ack_i = 1'b0; bus_if.bus_data_i = $urandom;
    #1;
    check("accept_stallreq", 32'(stallreq), 32'd1);
    check("accept_state", 32'(dbg_state), 32'(IfIdle));
    check("accept_cyc", 32'(bus_if.bus_cyc_o), 32'd0);
    check("accept_inst", inst_o, NOP);
    step();

    for (int k = 1; k <= ack_k; k++) begin
      ce_i  = 1'($urandom_range(0, 1));
      pc_i  = $urandom;
      flush = (k == flush_at);
      bus_if.bus_ack_i  = (k == ack_k);
      bus_if.bus_data_i = (k == ack_k) ? data : $urandom;
      stall = (k == ack_k) ? ((hold > 0) ? 6'($urandom_range(1, 63)) : 6'd0)
                           : 6'($urandom_range(0, 63));
      #1;
      check("busy_cyc", 32'(bus_if.bus_cyc_o), 32'd1);
      check("busy_stb", 32'(bus_if.bus_stb_o), 32'd1);
      check("busy_addr", bus_if.bus_addr_o, {pc[31:2], 2'b00});
      check("busy_exc", excepttype_o, 32'h0);
      check("busy_state", 32'(dbg_state), drained ? 32'(IfDrain) : 32'(IfBusy));
      if (bus_if.bus_ack_i && !flush && !drained) begin
        check("ack_stallreq", 32'(stallreq), 32'd0);
        check("ack_inst", inst_o, data);
      end else if (bus_if.bus_ack_i) begin
        check("discard_inst", inst_o, NOP);
        if (drained) check("drain_ack_stallreq", 32'(stallreq), 32'd1);
      end else begin
        check("wait_stallreq", 32'(stallreq), 32'd1);
        check("wait_inst", inst_o, NOP);
      end
      if (flush && !bus_if.bus_ack_i) drained = 1'b1;
      step();
    end

    completed = !drained && (flush_at != ack_k);
    bus_if.bus_ack_i = 1'b0; flush = 1'b0;
    if (completed && hold > 0) begin
      for (int h = 0; h <= hold; h++) begin
        ce_i  = 1'b1; pc_i = $urandom;
        stall = (h < hold) ? 6'($urandom_range(1, 63)) : 6'd0;
        flush = flush_in_hold && (h == 0);
        #1;
        check("hold_state", 32'(dbg_state), 32'(IfHold));
        check("hold_inst", inst_o, data);
        check("hold_stallreq", 32'(stallreq), 32'd0);
        check("hold_cyc", 32'(bus_if.bus_cyc_o), 32'd0);
        step();
        if (flush) break;
      end
      flush = 1'b0;
    end

    ce_i = 1'b0; stall = 6'd0;
    #1;
    check("post_state", 32'(dbg_state), 32'(IfIdle));
    check("post_cyc", 32'(bus_if.bus_cyc_o), 32'd0);
    check("post_stb", 32'(bus_if.bus_stb_o), 32'd0);
    check("post_stallreq", 32'(stallreq), 32'd0);
    check("post_inst", inst_o, NOP);
    step();
  endtask

  initial begin
    int waits;
    int flush_at;
    int hold;

    rst = 1'b1; ce_i = 1'b0; pc_i = 32'h0; excepttype_i = 32'h0000_0010;
    stall = 6'd0; flush = 1'b0;
    bus_if.bus_ack_i = 1'b0; bus_if.bus_data_i = 32'h0;
    @(negedge clk);
    step();
    #1;
    check("rst_state", 32'(dbg_state), 32'(IfIdle));
    check("rst_cyc", 32'(bus_if.bus_cyc_o), 32'd0);
    check("rst_stb", 32'(bus_if.bus_stb_o), 32'd0);
    check("rst_addr", bus_if.bus_addr_o, 32'h0);
    check("rst_stallreq", 32'(stallreq), 32'd0);
    check("rst_inst", inst_o, NOP);
    check("rst_exc", excepttype_o, 32'h0000_0010);
    rst = 1'b0;
    step();

    fetch(32'hBFC0_0000, 32'h3C01_1234, 0, 0, 0, 1'b0);   // plain fetch
    fetch(32'hBFC0_0006, 32'h2402_0001, 3, 0, 0, 1'b0);   // wait states, unaligned pc
    fetch(32'hBFC0_0010, 32'hDEAD_BEEF, 3, 2, 0, 1'b0);   // flush mid-fetch -> drain
    fetch(32'hBFC0_0020, 32'h0000_1111, 1, 2, 0, 1'b0);   // flush with ack
    fetch(32'hBFC0_0030, 32'h8C22_0004, 0, 0, 3, 1'b0);   // stall on completion
    fetch(32'hBFC0_0040, 32'h8C22_0008, 1, 0, 2, 1'b1);   // flush releases hold

    // TLB miss in IDLE: no bus cycle, exception passes through
    ce_i = 1'b1; pc_i = 32'hBFC0_0050; excepttype_i = 32'h0000_2000;
    #1;
    check("tlb_stallreq", 32'(stallreq), 32'd0);
    check("tlb_inst", inst_o, NOP);
    check("tlb_exc", excepttype_o, 32'h0000_2000);
    step();
    #1;
    check("tlb_cyc", 32'(bus_if.bus_cyc_o), 32'd0);
    check("tlb_state", 32'(dbg_state), 32'(IfIdle));
    excepttype_i = 32'h0; ce_i = 1'b0;
    step();

    // Reset while waiting for ack
    ce_i = 1'b1; pc_i = 32'hBFC0_0060;
    step();
    ce_i = 1'b0;
    #1;
    check("rstbusy_cyc_before", 32'(bus_if.bus_cyc_o), 32'd1);
    step();
    rst = 1'b1;
    step();
    #1;
    check("rstbusy_cyc", 32'(bus_if.bus_cyc_o), 32'd0);
    check("rstbusy_stb", 32'(bus_if.bus_stb_o), 32'd0);
    check("rstbusy_state", 32'(dbg_state), 32'(IfIdle));
    check("rstbusy_stallreq", 32'(stallreq), 32'd0);
    rst = 1'b0;
    step();

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      waits    = $urandom_range(0, 3);
      flush_at = ($urandom_range(0, 9) < 4) ? $urandom_range(1, waits + 1) : 0;
      hold     = (flush_at == 0) ? $urandom_range(0, 2) : 0;
      fetch($urandom, $urandom | 32'h1, waits, flush_at, hold,
            1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
